// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
//
// Buffered 8N1 UART transmitter for the debug/monitor port. Bytes are pushed
// into a small FIFO. They are serialised LSB first onto tx at CLK_DIV clocks
// per bit. Frames go out back-to-back for as long as the FIFO holds data.
//
// Parameters:
//   CLK_DIV    clock cycles per bit (>= 2)
//   FIFO_DEPTH byte entries, power of two, >= 2
//   CNT_W      width of fifo_count, log2(FIFO_DEPTH)+1
//
// Ports:
//   clk        system clock (only clock)
//   rst        synchronous active-high reset; aborts any frame, empties FIFO
//   wdata      byte to send
//   wvalid     write request
//   wready     FIFO can accept a byte (fifo_count != FIFO_DEPTH)
//   tx         serial output, idles high (registered)
//   busy       a frame is in progress (registered)
//   fifo_count bytes queued, excluding the byte being shifted (registered)
//
// Handshake: a byte transfers on the rising edge where wvalid && wready are
// both high. wvalid may be raised or held at any time; a request seen with
// wready low is simply not taken (no overwrite, no error flag). wready depends
// only on fifo_count, never on wvalid, so there is no combinational loop.
// While rst is high, requests are ignored.
// -----------------------------------------------------------------------------
module uart_tx_buffered #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       wdata,
    input  logic             wvalid,
    output logic             wready,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  count_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [7:0]        mem [FIFO_DEPTH];
    logic              push, pop;

    assign wready     = (count_q != FULL);
    assign push       = wvalid && wready;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

    // FIFO storage has no reset; fifo_count alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Next-state and next-output logic. tx_d is the level tx will carry for
    // the next bit, so tx changes on the same edge the state does.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    state_d = START;
                    baud_d  = BAUD_LOAD;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    state_d = DATA;
                    baud_d  = BAUD_LOAD;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_LOAD;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // Shift right so the next bit to send is always at [0];
                        // shift_q[1] becomes the new output bit.
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_q == '0) begin
                    if (count_q != '0) begin
                        // Chain straight into the next start bit, no idle gap.
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = START;
                        baud_d  = BAUD_LOAD;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        baud_d  = '0;
                        bit_d   = 3'd0;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
`timescale 1ns/1ps
module tb_uart_tx_buffered;

    localparam int DIV_A = 16;
    localparam int DIV_B = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] wdata = 8'd0;
    logic wvalid16 = 1'b0;
    logic wvalid2  = 1'b0;

    logic       wready16, tx16, busy16;
    logic [2:0] count16;
    logic       wready2, tx2, busy2;
    logic [2:0] count2;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_buffered #(.CLK_DIV(DIV_A), .FIFO_DEPTH(4), .CNT_W(3)) dut16 (
        .clk(clk), .rst(rst), .wdata(wdata), .wvalid(wvalid16),
        .wready(wready16), .tx(tx16), .busy(busy16), .fifo_count(count16)
    );

    uart_tx_buffered #(.CLK_DIV(DIV_B), .FIFO_DEPTH(4), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst), .wdata(wdata), .wvalid(wvalid2),
        .wready(wready2), .tx(tx2), .busy(busy2), .fifo_count(count2)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] exp16_q[$];
    logic [9:0] exp2_q[$];
    logic [9:0] rx16_q[$];
    logic [9:0] rx2_q[$];
    int         rx16_t[$];

    // Frame as seen on the wire: bit 0 = start, bits 1..8 = data LSB first,
    // bit 9 = stop.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    function automatic logic get_tx(input logic sel);
        return sel ? tx2 : tx16;
    endfunction
    function automatic logic get_busy(input logic sel);
        return sel ? busy2 : busy16;
    endfunction
    function automatic logic [2:0] get_count(input logic sel);
        return sel ? count2 : count16;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- receiver monitor ----------------
    // Independent 8N1 receiver: detects the start bit, samples every bit at
    // its centre and pushes the 10-bit frame. Reset aborts a frame in flight.
    int         mon_c [2];
    int         mon_s [2];
    logic [9:0] mon_f [2];
    initial begin
        logic txv;
        int   div;
        mon_c[0] = -1;
        mon_c[1] = -1;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                txv = (d == 1) ? tx2 : tx16;
                div = (d == 1) ? DIV_B : DIV_A;
                if (rst) begin
                    mon_c[d] = -1;
                end else if (mon_c[d] < 0) begin
                    if (txv === 1'b0) begin
                        mon_c[d] = 0;
                        mon_s[d] = cyc;
                        mon_f[d] = '0;
                    end
                end else begin
                    mon_c[d]++;
                    if (mon_c[d] % div == div / 2) mon_f[d][mon_c[d] / div] = txv;
                    if (mon_c[d] == 9 * div + div / 2) begin
                        if (d == 1) begin
                            rx2_q.push_back(mon_f[d]);
                        end else begin
                            rx16_q.push_back(mon_f[d]);
                            rx16_t.push_back(mon_s[d]);
                        end
                        mon_c[d] = -1;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) step();
    endtask

    task automatic clear_queues();
        exp16_q.delete();
        exp2_q.delete();
        rx16_q.delete();
        rx2_q.delete();
        rx16_t.delete();
    endtask

    // Drives one write request for one cycle; the caller states whether the
    // block is expected to accept it, which decides what the scoreboard expects.
    task automatic write_byte(input logic sel, input logic [7:0] b, input logic expect_accept);
        wdata = b;
        if (sel) wvalid2 = 1'b1;
        else     wvalid16 = 1'b1;
        step();
        wvalid2  = 1'b0;
        wvalid16 = 1'b0;
        if (expect_accept) begin
            if (sel) exp2_q.push_back(frame_of(b));
            else     exp16_q.push_back(frame_of(b));
        end
    endtask

    task automatic wait_tx_low(input logic sel, input int bound);
        int n;
        n = 0;
        while (get_tx(sel) !== 1'b0 && n < bound) begin
            step();
            n++;
        end
        check("tx_start_timeout", {31'd0, (n >= bound)}, 32'd0);
    endtask

    task automatic wait_busy_low(input logic sel, input int bound, output int fall_cyc);
        int n;
        n = 0;
        while (get_busy(sel) !== 1'b0 && n < bound) begin
            step();
            n++;
        end
        check("busy_fall_timeout", {31'd0, (n >= bound)}, 32'd0);
        fall_cyc = cyc;
    endtask

    task automatic compare_frames(input logic sel, input string name);
        int ng, nw;
        logic [9:0] got, want;
        ng = sel ? rx2_q.size() : rx16_q.size();
        nw = sel ? exp2_q.size() : exp16_q.size();
        check({name, "_frame_count"}, ng, nw);
        for (int i = 0; i < ng && i < nw; i++) begin
            got  = sel ? rx2_q[i] : rx16_q[i];
            want = sel ? exp2_q[i] : exp16_q[i];
            check({name, "_frame"}, {22'd0, got}, {22'd0, want});
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       sel;      // 0: CLK_DIV=16 instance, 1: CLK_DIV=2 instance
        logic [7:0] data;
        logic [9:0] frame;    // hand-computed wire frame, bit 0 first
    } vec_t;

    vec_t vecs [7];

    // ---------------- test sequence ----------------
    initial begin
        int fall;
        int div;
        int n;
        int s0;
        logic bad;

        vecs[0] = '{1'b0, 8'hA5, 10'b1101001010};
        vecs[1] = '{1'b0, 8'h5A, 10'b1010110100};
        vecs[2] = '{1'b0, 8'h81, 10'b1100000010};
        vecs[3] = '{1'b0, 8'hFF, 10'b1111111110};
        vecs[4] = '{1'b1, 8'h3C, 10'b1001111000};
        vecs[5] = '{1'b1, 8'hC6, 10'b1110001100};
        vecs[6] = '{1'b1, 8'h00, 10'b1000000000};

        // Reset values, held steady for 50 cycles after release.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            check("rst_tx16",     {31'd0, tx16},     32'd1);
            check("rst_busy16",   {31'd0, busy16},   32'd0);
            check("rst_count16",  {29'd0, count16},  32'd0);
            check("rst_wready16", {31'd0, wready16}, 32'd1);
            check("rst_tx2",      {31'd0, tx2},      32'd1);
            check("rst_busy2",    {31'd0, busy2},    32'd0);
            check("rst_count2",   {29'd0, count2},   32'd0);
            check("rst_wready2",  {31'd0, wready2},  32'd1);
            step();
        end

        // Single-byte frames from the table, both dividers.
        for (int i = 0; i < 7; i++) begin
            clear_queues();
            div = vecs[i].sel ? DIV_B : DIV_A;
            write_byte(vecs[i].sel, vecs[i].data, 1'b1);
            check("vec_count_accept", {29'd0, get_count(vecs[i].sel)}, 32'd1);
            step();
            check("vec_tx_fall",    {31'd0, get_tx(vecs[i].sel)},    32'd0);
            check("vec_busy_rise",  {31'd0, get_busy(vecs[i].sel)},  32'd1);
            check("vec_count_pop",  {29'd0, get_count(vecs[i].sel)}, 32'd0);
            n = 0;
            while (get_busy(vecs[i].sel) === 1'b1 && n < 20 * div) begin
                n++;
                step();
            end
            check("vec_busy_cycles", n, 10 * div);
            check("vec_tx_idle", {31'd0, get_tx(vecs[i].sel)}, 32'd1);
            n = vecs[i].sel ? rx2_q.size() : rx16_q.size();
            check("vec_frame_count", n, 1);
            if (n > 0) begin
                check("vec_frame",
                      {22'd0, (vecs[i].sel ? rx2_q[0] : rx16_q[0])},
                      {22'd0, vecs[i].frame});
            end
            repeat (5) step();
        end

        // Fill the FIFO during a frame; a write while full is dropped.
        clear_queues();
        write_byte(1'b0, 8'h00, 1'b1);
        wait_tx_low(1'b0, 10);
        write_byte(1'b0, 8'h11, 1'b1);
        write_byte(1'b0, 8'h22, 1'b1);
        write_byte(1'b0, 8'h33, 1'b1);
        check("fill_wready_at3", {31'd0, wready16}, 32'd1);
        write_byte(1'b0, 8'h44, 1'b1);
        check("fill_count4",      {29'd0, count16},  32'd4);
        check("fill_wready_low",  {31'd0, wready16}, 32'd0);
        write_byte(1'b0, 8'h55, 1'b0);
        check("fill_drop_count",  {29'd0, count16},  32'd4);
        wait_busy_low(1'b0, 1200, fall);
        compare_frames(1'b0, "fill");
        if (rx16_t.size() == 5) begin
            for (int i = 1; i < 5; i++) check("fill_gap", rx16_t[i] - rx16_t[i-1], 160);
            check("fill_span", fall - rx16_t[0], 800);
        end
        repeat (5) step();

        // Push on the pop edge at the end of STOP, with count held at 2.
        clear_queues();
        write_byte(1'b0, 8'hC3, 1'b1);
        s0 = cyc + 1;
        write_byte(1'b0, 8'h5A, 1'b1);          // lands on the IDLE pop edge
        check("pp_start",        {31'd0, tx16},    32'd0);
        check("pp_count_idlepop", {29'd0, count16}, 32'd1);
        write_byte(1'b0, 8'hE7, 1'b1);
        check("pp_count2",       {29'd0, count16}, 32'd2);
        wait_cyc(s0 + 159);
        check("pp_before1",      {29'd0, count16}, 32'd2);
        write_byte(1'b0, 8'h96, 1'b1);
        check("pp_after1",       {29'd0, count16}, 32'd2);
        check("pp_restart1",     {31'd0, tx16},    32'd0);
        wait_cyc(s0 + 319);
        check("pp_before2",      {29'd0, count16}, 32'd2);
        write_byte(1'b0, 8'h69, 1'b1);
        check("pp_after2",       {29'd0, count16}, 32'd2);
        check("pp_restart2",     {31'd0, tx16},    32'd0);
        wait_busy_low(1'b0, 1200, fall);
        check("pp_span", fall - s0, 800);
        compare_frames(1'b0, "pp");
        repeat (5) step();

        // Ten sequential bytes wrap both pointers more than once.
        clear_queues();
        for (int b = 1; b <= 10; b++) begin
            n = 0;
            while (wready16 !== 1'b1 && n < 400) begin
                step();
                n++;
            end
            check("wrap_wready_timeout", {31'd0, (n >= 400)}, 32'd0);
            write_byte(1'b0, 8'(b), 1'b1);
        end
        wait_busy_low(1'b0, 2000, fall);
        compare_frames(1'b0, "wrap");
        repeat (5) step();

        // Reset during data bit 3 of 0xFF with two bytes queued.
        clear_queues();
        write_byte(1'b0, 8'hFF, 1'b1);
        wait_tx_low(1'b0, 10);
        s0 = cyc;
        write_byte(1'b0, 8'h12, 1'b1);
        write_byte(1'b0, 8'h34, 1'b1);
        check("mid_count2", {29'd0, count16}, 32'd2);
        wait_cyc(s0 + 70);
        rst = 1'b1;
        wdata = 8'h77;
        wvalid16 = 1'b1;                         // must be ignored under reset
        step();
        check("mid_tx",     {31'd0, tx16},     32'd1);
        check("mid_busy",   {31'd0, busy16},   32'd0);
        check("mid_count",  {29'd0, count16},  32'd0);
        check("mid_wready", {31'd0, wready16}, 32'd1);
        wvalid16 = 1'b0;
        rst = 1'b0;
        exp16_q.delete();
        rx16_q.delete();
        bad = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (tx16 !== 1'b1 || busy16 !== 1'b0 || count16 !== 3'd0) bad = 1'b1;
        end
        check("mid_quiet_after_release", {31'd0, bad}, 32'd0);
        check("mid_no_frames", rx16_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
